ibex_regfile_dump_reader: RTL



---
 rtl/ibex_regfile_dump_reader_pkg.sv | 23 ++
 rtl/ibex_regfile_dump_reader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ibex_regfile_dump_reader_pkg.sv
//------------------------------------------------------------------------------
// ibex_regfile_dump_reader_pkg: shared types for the register-file dump reader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ibex_regfile_dump_reader_pkg;

    typedef enum logic [1:0] {
        REGDUMP_IDLE   = 2'd0,
        REGDUMP_FETCH  = 2'd1,
        REGDUMP_STREAM = 2'd2,
        REGDUMP_DONE   = 2'd3
    } regdump_state_e;

    // x0 is hardwired to zero, so a dump may begin past it.
    function automatic int unsigned regdump_first_idx(input bit skip_zero);
        return skip_zero ? 1 : 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_regfile_dump_reader.sv
//------------------------------------------------------------------------------
// ibex_regfile_dump_reader: walks the register file through one async read
// port, streams (addr, data) beats over valid/ready and XORs them together.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ibex_regfile_dump_reader
    import ibex_regfile_dump_reader_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumRegs    = 32,
    parameter bit          SkipZero   = 1'b1,
    localparam int unsigned ADDR_WIDTH = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [DataWidth-1:0]  rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DataWidth-1:0]  out_data_o,
    output logic                  out_last_o,
    output logic [DataWidth-1:0]  checksum_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NumRegs - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(regdump_first_idx(SkipZero));

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DataWidth-1:0]  data;
        logic                  last;
    } beat_t;

    regdump_state_e        state_q;
    regdump_state_e        state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] idx_next;
    beat_t                 beat_q;
    beat_t                 fetched;
    logic                  valid_q;
    logic [DataWidth-1:0]  checksum_q;
    logic                  handshake;
    logic                  load;
    logic                  begin_dump;
    logic                  fold;

    assign handshake = valid_q & out_ready_i;
    assign fetched   = '{addr: idx_q, data: rdata_i, last: (idx_q == LAST_IDX)};
    // Saturate so raddr_o never points past the last register.
    assign idx_next  = (idx_q == LAST_IDX) ? idx_q : idx_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        begin_dump = 1'b0;
        fold       = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            REGDUMP_IDLE: begin
                if (start_i) begin
                    begin_dump = 1'b1;
                    state_d    = REGDUMP_FETCH;
                end
            end
            REGDUMP_FETCH: begin
                if (abort_i) begin
                    state_d = REGDUMP_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = REGDUMP_STREAM;
                end
            end
            REGDUMP_STREAM: begin
                // Abort wins over a handshake in the same cycle.
                if (abort_i) begin
                    state_d = REGDUMP_IDLE;
                end else if (handshake) begin
                    fold = 1'b1;
                    if (beat_q.last) begin
                        state_d = REGDUMP_DONE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            REGDUMP_DONE: begin
                done_o  = ~abort_i;
                state_d = REGDUMP_IDLE;
            end
            default: state_d = REGDUMP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= REGDUMP_IDLE;
            idx_q      <= '0;
            beat_q     <= '0;
            valid_q    <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == REGDUMP_STREAM);
            if (begin_dump) begin
                idx_q <= FIRST_IDX;
            end else if (load) begin
                idx_q <= idx_next;
            end
            if (load) begin
                beat_q <= fetched;
            end
            if (begin_dump) begin
                checksum_q <= '0;
            end else if (fold) begin
                checksum_q <= checksum_q ^ beat_q.data;
            end
        end
    end

    assign busy_o      = (state_q != REGDUMP_IDLE);
    assign raddr_o     = idx_q;
    assign out_valid_o = valid_q;
    assign out_addr_o  = beat_q.addr;
    assign out_data_o  = beat_q.data;
    assign out_last_o  = beat_q.last;
    assign checksum_o  = checksum_q;

    // A one-entry file with x0 skipped would have nothing to dump.
    cfg_legal_a: assert property (@(posedge clk_i) !((NumRegs == 1) && SkipZero));
    idx_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni) idx_q <= LAST_IDX);

endmodule

`default_nettype wire
